// File: rtl/rotary_quad_ctrl_if.sv
// Signal bundle between the rotary encoder front end and its user.
// The master side drives the encoder pins and control strobes; the slave side
// (the controller) drives the value, published address and step indicators.
interface rotary_quad_ctrl_if #(
  parameter int unsigned VAL_W = 11,
  parameter int unsigned NSTEP = 3
);
  logic             Rot_A;
  logic             Rot_B;
  logic             Rot_C;
  logic             Floor_En;
  logic             Load_En;
  logic [VAL_W-1:0] Load_Val;
  logic [VAL_W-1:0] Value;
  logic [VAL_W-1:0] Address;
  logic             FreqChng;
  logic [1:0]       StepSel;
  logic [NSTEP-1:0] LedStep;

  modport master (
    output Rot_A, Rot_B, Rot_C, Floor_En, Load_En, Load_Val,
    input  Value, Address, FreqChng, StepSel, LedStep
  );

  modport slave (
    input  Rot_A, Rot_B, Rot_C, Floor_En, Load_En, Load_Val,
    output Value, Address, FreqChng, StepSel, LedStep
  );
endinterface

// File: rtl/rotary_quad_ctrl.sv
// Rotary encoder front end: synchronises and debounces A/B/C, decodes one
// quadrature detent per step, keeps a saturating value register with selectable
// step size, floor mode and preset load, and publishes a rate-limited copy.
module rotary_quad_ctrl #(
  parameter int unsigned VAL_W     = 11,
  parameter int unsigned MAX_VAL   = 1799,
  parameter int unsigned MIN_VAL   = 0,
  parameter int unsigned FLOOR_VAL = 800,
  parameter int unsigned NSTEP     = 3,
  parameter int unsigned STEP0     = 1,
  parameter int unsigned STEP1     = 10,
  parameter int unsigned STEP2     = 100,
  parameter int unsigned STEP3     = 1000,
  parameter int unsigned DEB_CYC   = 256,
  parameter int unsigned UPD_CYC   = 2400000
) (
  input logic               Fg_CLK,
  input logic               RESET,
  rotary_quad_ctrl_if.slave bus
);

  localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);
  localparam int unsigned TMR_W = (UPD_CYC > 1) ? $clog2(UPD_CYC) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(UPD_CYC - 1);

  // Arithmetic constants carry one guard bit so sums never wrap.
  localparam logic [VAL_W:0] MAX_W   = (VAL_W + 1)'(MAX_VAL);
  localparam logic [VAL_W:0] MIN_W   = (VAL_W + 1)'(MIN_VAL);
  localparam logic [VAL_W:0] FLOOR_W = (VAL_W + 1)'(FLOOR_VAL);
  localparam logic [VAL_W:0] STEP0_W = (VAL_W + 1)'(STEP0);
  localparam logic [VAL_W:0] STEP1_W = (VAL_W + 1)'(STEP1);
  localparam logic [VAL_W:0] STEP2_W = (VAL_W + 1)'(STEP2);
  localparam logic [VAL_W:0] STEP3_W = (VAL_W + 1)'(STEP3);

  localparam logic [VAL_W-1:0] MIN_V    = VAL_W'(MIN_VAL);
  localparam logic [1:0]       LAST_SEL = 2'(NSTEP - 1);
  localparam logic [NSTEP-1:0] LED_ONE  = NSTEP'(1);

  // Bit order {C, B, A}; A and B idle high, C idles low.
  localparam logic [2:0] IDLE_LVL = 3'b011;

  typedef enum logic [1:0] {StIdle, StCw1, StCcw1, StWait} dec_state_e;

  logic [2:0]       raw;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       filt_q, filt_prev_q;
  logic [DEB_W-1:0] deb_cnt_q [3];
  logic [1:0]       fall_ab;
  logic [2:0]       rise;

  dec_state_e state_q, state_d;
  logic       commit_up, commit_dn;

  logic [VAL_W-1:0] value_q, value_d;
  logic [VAL_W:0]   step_w, lo_w, val_w, sum_w, ld_w;
  logic [VAL_W-1:0] diff_v;

  logic [1:0]       step_sel_q, step_sel_d;
  logic [NSTEP-1:0] led_q;

  logic [TMR_W-1:0] tmr_q;
  logic             tick;
  logic [VAL_W-1:0] addr_q;
  logic             freq_q;

  assign raw = {bus.Rot_C, bus.Rot_B, bus.Rot_A};

  // Two-flop synchroniser for the asynchronous encoder pins.
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level only after DEB_CYC consecutive disagreeing cycles.
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      filt_q      <= IDLE_LVL;
      filt_prev_q <= IDLE_LVL;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
    end else begin
      filt_prev_q <= filt_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          filt_q[i]    <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  assign fall_ab = filt_prev_q[1:0] & ~filt_q[1:0];
  assign rise    = ~filt_prev_q & filt_q;

  // Decoder state register.
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Detent decoder: first falling phase picks the direction, the other phase commits.
  always_comb begin
    state_d   = state_q;
    commit_up = 1'b0;
    commit_dn = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall_ab[0] && fall_ab[1]) state_d = StWait;  // ambiguous, ignore detent
        else if (fall_ab[1])          state_d = StCw1;
        else if (fall_ab[0])          state_d = StCcw1;
      end
      StCw1: begin
        if (fall_ab[0]) begin
          commit_up = 1'b1;
          state_d   = StWait;
        end else if (rise[1]) begin
          state_d = StIdle;
        end
      end
      StCcw1: begin
        if (fall_ab[1]) begin
          commit_dn = 1'b1;
          state_d   = StWait;
        end else if (rise[0]) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (filt_q[0] && filt_q[1]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Step size for the current selection.
  always_comb begin
    step_w = STEP0_W;
    case (step_sel_q)
      2'd0:    step_w = STEP0_W;
      2'd1:    step_w = STEP1_W;
      2'd2:    step_w = STEP2_W;
      default: step_w = STEP3_W;
    endcase
  end

  // Next value: load beats floor raise beats decoder commit; every path saturates.
  always_comb begin
    value_d = value_q;
    lo_w    = bus.Floor_En ? FLOOR_W : MIN_W;
    val_w   = {1'b0, value_q};
    sum_w   = val_w + step_w;
    ld_w    = {1'b0, bus.Load_Val};
    diff_v  = value_q - step_w[VAL_W-1:0];
    if (bus.Load_En) begin
      if (ld_w > MAX_W)     value_d = MAX_W[VAL_W-1:0];
      else if (ld_w < lo_w) value_d = lo_w[VAL_W-1:0];
      else                  value_d = bus.Load_Val;
    end else if (bus.Floor_En && (val_w < FLOOR_W)) begin
      value_d = FLOOR_W[VAL_W-1:0];
    end else if (commit_up) begin
      value_d = (sum_w > MAX_W) ? MAX_W[VAL_W-1:0] : sum_w[VAL_W-1:0];
    end else if (commit_dn) begin
      value_d = (val_w < lo_w + step_w) ? lo_w[VAL_W-1:0] : diff_v;
    end
  end

  // Step selection advances on each debounced button press, wrapping at NSTEP.
  always_comb begin
    step_sel_d = step_sel_q;
    if (rise[2]) step_sel_d = (step_sel_q == LAST_SEL) ? 2'd0 : step_sel_q + 2'd1;
  end

  // Value, step index and one-cold LED registers.
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      value_q    <= MIN_V;
      step_sel_q <= 2'd0;
      led_q      <= ~LED_ONE;
    end else begin
      value_q    <= value_d;
      step_sel_q <= step_sel_d;
      led_q      <= ~(LED_ONE << step_sel_d);
    end
  end

  assign tick = (tmr_q == TMR_LAST);

  // Publish timer: copy the value out once per period, pulse only on a real change.
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      tmr_q  <= '0;
      addr_q <= MIN_V;
      freq_q <= 1'b0;
    end else begin
      tmr_q <= tick ? '0 : tmr_q + TMR_W'(1);
      if (tick) begin
        addr_q <= value_q;
        freq_q <= (addr_q != value_q);
      end else begin
        freq_q <= 1'b0;
      end
    end
  end

  assign bus.Value    = value_q;
  assign bus.Address  = addr_q;
  assign bus.FreqChng = freq_q;
  assign bus.StepSel  = step_sel_q;
  assign bus.LedStep  = led_q;

endmodule
